// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider and tick generator.
// Define CLK_DIV_MULTI_SHADOW_EN for shadowed divisor writes committed at period boundaries.
module clk_div_multi #(
    parameter int INPUT_FREQ  = 50_000_000,
    parameter int OUTPUT_FREQ = 20_000_000,
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int SEL_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_s_n,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 sync,
    input  logic                 div_we,
    input  logic [SEL_WIDTH-1:0] div_sel,
    input  logic [CNT_WIDTH-1:0] div_data,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  tick,
    output logic [CHANNELS-1:0]  pending
);
    localparam int RAW_DIV = INPUT_FREQ / OUTPUT_FREQ;
    localparam logic [CNT_WIDTH-1:0] MIN_DIV     = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_DIV = (RAW_DIV < 2) ? MIN_DIV : CNT_WIDTH'(RAW_DIV);

    // Divisors below 2 cannot produce a clock, so they are stored as 2.
    logic [CNT_WIDTH-1:0] wr_div;
    assign wr_div = (div_data < MIN_DIV) ? MIN_DIV : div_data;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] div;
        logic                 wr_hit;
        logic                 at_wrap;
        logic                 clk_q;
        logic                 tick_q;

        assign wr_hit     = div_we && (int'(div_sel) == i);
        assign at_wrap    = (cnt == div - ONE);
        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;

`ifdef CLK_DIV_MULTI_SHADOW_EN
        logic [CNT_WIDTH-1:0] shadow;
        logic                 pend_q;

        // Every restart point (wrap, sync, disabled) commits shadow; a write on that edge stays pending.
        always_ff @(posedge clk_in) begin
            if (!rst_s_n) begin
                cnt    <= '0;
                div    <= DEFAULT_DIV;
                shadow <= DEFAULT_DIV;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!en[i]) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                div    <= shadow;
                pend_q <= 1'b0;
                if (wr_hit) begin
                    shadow <= wr_div;
                    pend_q <= 1'b1;
                end
            end else begin
                clk_q  <= (cnt < (div >> 1));
                tick_q <= at_wrap;
                if (sync || at_wrap) begin
                    cnt    <= '0;
                    div    <= shadow;
                    pend_q <= 1'b0;
                end else begin
                    cnt <= cnt + ONE;
                end
                if (wr_hit) begin
                    shadow <= wr_div;
                    pend_q <= 1'b1;
                end
            end
        end

        assign pending[i] = pend_q;
`else
        // Without shadowing a write takes effect at once and restarts the channel.
        always_ff @(posedge clk_in) begin
            if (!rst_s_n) begin
                cnt    <= '0;
                div    <= DEFAULT_DIV;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (wr_hit) begin
                cnt    <= '0;
                div    <= wr_div;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!en[i]) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                clk_q  <= (cnt < (div >> 1));
                tick_q <= at_wrap;
                cnt    <= (sync || at_wrap) ? '0 : cnt + ONE;
            end
        end

        assign pending[i] = 1'b0;
`endif
    end
endmodule
